// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared FSM/kind enums, privilege constants and CPU widths for the trap controller
package trap_ctrl_pkg;
  localparam int XLEN = 32;
  localparam int IM_ADDR_LEN = 32;
  localparam logic [1:0] PRV_U = 2'd0;
  localparam logic [1:0] PRV_S = 2'd1;
  localparam logic [1:0] PRV_M = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_COMMIT, ST_REDIRECT} state_e;
  typedef enum logic [1:0] {K_TRAP, K_MRET, K_SRET} kind_e;
endpackage

// File: rtl/trap_deleg.sv
// trap_deleg: decides whether a synchronous exception is delegated to S-mode through medeleg
module trap_deleg
  import trap_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] cause,
  input  logic [1:0]      prv_cur,
  input  logic [XLEN-1:0] medeleg,
  output logic            deleg_s
);
  localparam int CW = $clog2(XLEN);
  // M-mode traps never delegate; causes beyond the medeleg width (incl. interrupts) stay in M
  assign deleg_s = (prv_cur != PRV_M) && (cause < XLEN) && medeleg[cause[CW-1:0]];
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences trap/xRET handling as flush -> CSR commit -> PC redirect; S-mode support under TRAP_SMODE_EN
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   trap_en,
  input  logic [XLEN-1:0]        trap_cause,
  input  logic [IM_ADDR_LEN-1:0] trap_epc,
  input  logic [XLEN-1:0]        trap_val,
  input  logic                   mret,
  input  logic                   sret,
  input  logic [1:0]             prv_cur,
  input  logic [XLEN-1:0]        medeleg,
  input  logic [XLEN-1:0]        mtvec,
  input  logic [XLEN-1:0]        stvec,
  input  logic [IM_ADDR_LEN-1:0] mepc,
  input  logic [IM_ADDR_LEN-1:0] sepc,
  input  logic                   spp,
  input  logic [1:0]             mpp,
  input  logic                   drain_done,
  output logic                   flush_req,
  output logic                   csr_trap_wr,
  output logic                   csr_trap_s,
  output logic [XLEN-1:0]        csr_cause,
  output logic [XLEN-1:0]        csr_val,
  output logic [IM_ADDR_LEN-1:0] csr_epc,
  output logic                   csr_ret_wr,
  output logic [1:0]             prv_nxt,
  output logic                   redirect_en,
  output logic [IM_ADDR_LEN-1:0] redirect_pc,
  output logic                   busy
);
  state_e state_q, state_d;
  kind_e kind_q, kind_d;
  logic [XLEN-1:0] cause_q, val_q;
  logic [IM_ADDR_LEN-1:0] epc_q, redir_pc_q;
  logic deleg_q, flush_q, trap_wr_q, ret_wr_q, trap_s_q, redir_q;
  logic [1:0] prv_q;
  logic deleg, sret_ok, spp_v;
  logic [XLEN-1:0] stvec_v;
  logic [IM_ADDR_LEN-1:0] sepc_v;
`ifdef TRAP_SMODE_EN
  trap_deleg u_deleg (.cause(trap_cause), .prv_cur(prv_cur), .medeleg(medeleg), .deleg_s(deleg));
  assign sret_ok = sret;
  assign spp_v = spp;
  assign stvec_v = stvec;
  assign sepc_v = sepc;
`else
  logic unused_smode;
  assign deleg = 1'b0;
  assign sret_ok = 1'b0;
  assign spp_v = 1'b0;
  assign stvec_v = '0;
  assign sepc_v = '0;
  assign unused_smode = ^{sret, stvec, sepc, medeleg, spp, prv_cur};
`endif
  logic unused_tvec;
  assign unused_tvec = ^{mtvec[1:0], stvec_v[1:0]};
  logic accept_trap, commit_go;
  logic [1:0] prv_sel;
  logic [IM_ADDR_LEN-1:0] target;
  assign accept_trap = (state_q == ST_IDLE) && trap_en;
  assign commit_go = (state_q == ST_FLUSH) && drain_done;
  assign prv_sel = kind_q == K_TRAP ? (deleg_q ? PRV_S : PRV_M) : kind_q == K_MRET ? mpp : {1'b0, spp_v};
  assign target = kind_q == K_TRAP ? (trap_s_q ? {stvec_v[IM_ADDR_LEN-1:2], 2'b00} : {mtvec[IM_ADDR_LEN-1:2], 2'b00})
                : kind_q == K_MRET ? mepc : sepc_v;
  // Next state: only IDLE accepts requests, trap beats a simultaneous xRET
  always_comb begin
    state_d = state_q;
    kind_d = kind_q;
    case (state_q)
      ST_IDLE: if (trap_en || mret || sret_ok) begin
        state_d = ST_FLUSH;
        kind_d = trap_en ? K_TRAP : mret ? K_MRET : K_SRET;
      end
      ST_FLUSH: if (drain_done) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_REDIRECT;
      default: state_d = ST_IDLE;
    endcase
  end
  // State, latched trap info and registered strobes; reset drops any sequence in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      kind_q <= K_TRAP;
      cause_q <= '0;
      epc_q <= '0;
      val_q <= '0;
      deleg_q <= 1'b0;
      flush_q <= 1'b0;
      trap_wr_q <= 1'b0;
      ret_wr_q <= 1'b0;
      trap_s_q <= 1'b0;
      prv_q <= '0;
      redir_q <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      state_q <= state_d;
      kind_q <= kind_d;
      flush_q <= state_d != ST_IDLE;
      if (accept_trap) begin
        cause_q <= trap_cause;
        epc_q <= trap_epc;
        val_q <= trap_val;
        deleg_q <= deleg;
      end
      trap_wr_q <= commit_go && kind_q == K_TRAP;
      ret_wr_q <= commit_go && kind_q != K_TRAP;
      if (commit_go) begin
        trap_s_q <= kind_q == K_TRAP && deleg_q;
        prv_q <= prv_sel;
      end
      redir_q <= state_q == ST_COMMIT;
      if (state_q == ST_COMMIT) redir_pc_q <= target;
    end
  end
  assign flush_req = flush_q;
  assign csr_trap_wr = trap_wr_q;
  assign csr_trap_s = trap_s_q;
  assign csr_cause = cause_q;
  assign csr_val = val_q;
  assign csr_epc = epc_q;
  assign csr_ret_wr = ret_wr_q;
  assign prv_nxt = prv_q;
  assign redirect_en = redir_q;
  assign redirect_pc = redir_pc_q;
  assign busy = state_q != ST_IDLE;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench for trap_ctrl; expectations depend on TRAP_SMODE_EN
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;
  logic clk = 0, rstn = 0, trap_en = 0, mret = 0, sret = 0, spp = 0, drain_done = 1;
  logic [31:0] trap_cause = 0, trap_epc = 0, trap_val = 0, medeleg = 32'h100;
  logic [31:0] mtvec = 32'h8000_0401, stvec = 32'h8000_0801, mepc = 32'h8000_1000, sepc = 32'h8000_2000;
  logic [1:0] prv_cur = PRV_M, mpp = 0, prv_nxt;
  logic flush_req, csr_trap_wr, csr_trap_s, csr_ret_wr, redirect_en, busy;
  logic [31:0] csr_cause, csr_val, csr_epc, redirect_pc;
  typedef struct {int typ; int cyc; logic s; logic [1:0] prv; logic [31:0] cause, epc, val, pc;} exp_t;
  exp_t q[$];
  exp_t m_e;
  int m_typ;
  int errors = 0, checks = 0, cyc = 0;

  trap_ctrl dut (.clk(clk), .rstn(rstn), .trap_en(trap_en), .trap_cause(trap_cause), .trap_epc(trap_epc),
    .trap_val(trap_val), .mret(mret), .sret(sret), .prv_cur(prv_cur), .medeleg(medeleg), .mtvec(mtvec),
    .stvec(stvec), .mepc(mepc), .sepc(sepc), .spp(spp), .mpp(mpp), .drain_done(drain_done),
    .flush_req(flush_req), .csr_trap_wr(csr_trap_wr), .csr_trap_s(csr_trap_s), .csr_cause(csr_cause),
    .csr_val(csr_val), .csr_epc(csr_epc), .csr_ret_wr(csr_ret_wr), .prv_nxt(prv_nxt),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string n, input logic [159:0] a, input logic [159:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
    end
  endtask

  task automatic push(input int typ, input int c, input logic s, input logic [1:0] prv,
                      input logic [31:0] cause, input logic [31:0] epc, input logic [31:0] val, input logic [31:0] pc);
    exp_t x;
    x.typ = typ; x.cyc = c; x.s = s; x.prv = prv; x.cause = cause; x.epc = epc; x.val = val; x.pc = pc;
    q.push_back(x);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // monitor: typ 0 = trap CSR write, 1 = xRET CSR write, 2 = redirect
  always @(negedge clk) begin
    if (rstn && (csr_trap_wr || csr_ret_wr || redirect_en)) begin
      m_typ = csr_trap_wr ? 0 : csr_ret_wr ? 1 : 2;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got type %0d at cycle %0d expected none", m_typ, cyc);
      end else begin
        m_e = q.pop_front();
        check("event_type", m_typ, m_e.typ);
        check("event_cycle", cyc, m_e.cyc);
        if (m_typ == 0) begin
          check("trap_s", csr_trap_s, m_e.s);
          check("trap_prv", prv_nxt, m_e.prv);
          check("trap_cause", csr_cause, m_e.cause);
          check("trap_epc", csr_epc, m_e.epc);
          check("trap_val", csr_val, m_e.val);
        end else if (m_typ == 1) check("ret_prv", prv_nxt, m_e.prv);
        else check("redirect_pc", redirect_pc, m_e.pc);
      end
    end
  end

  task automatic run_trap(input logic [31:0] c, input logic [31:0] e, input logic [31:0] v, input logic [1:0] p,
                          input logic s, input logic [1:0] pn, input logic [31:0] pc);
    prv_cur = p; trap_cause = c; trap_epc = e; trap_val = v; trap_en = 1;
    push(0, cyc + 2, s, pn, c, e, v, 0);
    push(2, cyc + 3, 0, 0, 0, 0, 0, pc);
    tick();
    trap_en = 0;
    check("busy_flush", {busy, flush_req}, 2'b11);
    repeat (3) tick();
    check("back_idle", {busy, flush_req}, 2'b00);
  endtask

  initial begin
    int n, fl;
    repeat (2) tick();
    check("reset_outputs", {flush_req, csr_trap_wr, csr_trap_s, csr_cause, csr_val, csr_epc, csr_ret_wr,
                            prv_nxt, redirect_en, redirect_pc, busy}, 0);
    #2 rstn = 1;
    tick();
    run_trap(2, 32'h8000_0100, 32'h13, PRV_M, 0, PRV_M, 32'h8000_0400);
`ifdef TRAP_SMODE_EN
    run_trap(8, 32'h8000_0180, 0, PRV_U, 1, PRV_S, 32'h8000_0800);
`else
    run_trap(8, 32'h8000_0180, 0, PRV_U, 0, PRV_M, 32'h8000_0400);
`endif
    run_trap(8, 32'h8000_0184, 0, PRV_M, 0, PRV_M, 32'h8000_0400);
    // drain stall: five cycles without drain_done
    drain_done = 0; prv_cur = PRV_M; trap_cause = 5; trap_epc = 32'h8000_0500; trap_val = 32'h55; trap_en = 1;
    n = cyc;
    push(0, n + 6, 0, PRV_M, 5, 32'h8000_0500, 32'h55, 0);
    push(2, n + 7, 0, 0, 0, 0, 0, 32'h8000_0400);
    fl = 0;
    repeat (5) begin
      tick();
      trap_en = 0;
      if (flush_req && !csr_trap_wr) fl++;
    end
    check("stall_flush_cycles", fl, 5);
    drain_done = 1;
    repeat (3) tick();
    check("stall_idle", busy, 0);
    // conflict with mret, then lockout during FLUSH
    drain_done = 0; trap_cause = 4; trap_epc = 32'h8000_0200; trap_val = 32'h44; trap_en = 1; mret = 1;
    n = cyc;
    push(0, n + 4, 0, PRV_M, 4, 32'h8000_0200, 32'h44, 0);
    push(2, n + 5, 0, 0, 0, 0, 0, 32'h8000_0400);
    tick();
    mret = 0; trap_cause = 6; trap_epc = 32'h8000_0300; trap_val = 32'h66;
    check("lock_busy", busy, 1);
    tick();
    trap_en = 0; mret = 1; sret = 1;
    check("lock_cause", csr_cause, 4);
    tick();
    mret = 0; sret = 0; drain_done = 1;
    check("lock_epc", csr_epc, 32'h8000_0200);
    repeat (3) tick();
    check("lock_idle", busy, 0);
    // MRET to S
    mpp = PRV_S; mret = 1;
    push(1, cyc + 2, 0, PRV_S, 0, 0, 0, 0);
    push(2, cyc + 3, 0, 0, 0, 0, 0, 32'h8000_1000);
    tick();
    mret = 0;
    repeat (3) tick();
    check("mret_idle", busy, 0);
    // SRET
    spp = 0; sret = 1;
`ifdef TRAP_SMODE_EN
    push(1, cyc + 2, 0, PRV_U, 0, 0, 0, 0);
    push(2, cyc + 3, 0, 0, 0, 0, 0, 32'h8000_2000);
    tick();
    sret = 0;
    repeat (3) tick();
`else
    tick();
    sret = 0;
    check("sret_ignored", {busy, flush_req}, 2'b00);
    repeat (3) tick();
`endif
    check("sret_idle", busy, 0);
    // reset while in COMMIT
    prv_cur = PRV_M; trap_cause = 2; trap_epc = 32'h8000_0700; trap_val = 32'h77; trap_en = 1;
    push(0, cyc + 2, 0, PRV_M, 2, 32'h8000_0700, 32'h77, 0);
    tick();
    trap_en = 0;
    tick();
    #2 rstn = 0;
    #1 check("async_reset_outputs", {flush_req, csr_trap_wr, csr_trap_s, csr_cause, csr_val, csr_epc, csr_ret_wr,
                                     prv_nxt, redirect_en, redirect_pc, busy}, 0);
    tick();
    #2 rstn = 1;
    repeat (4) tick();
    check("post_reset_idle", {busy, flush_req, redirect_en}, 0);
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule
